// File: rtl/types_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// types_pkg: shared result/broadcast types and helpers for the CDB arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
package types_pkg;

   localparam int CDB_FIFO_DEPTH = 2;

   typedef enum logic [1:0] {
      SRC_ALU = 2'd0,
      SRC_MEM = 2'd1,
      SRC_B   = 2'd2
   } src_e;

   typedef struct packed {
      logic [6:0]  p_alu;
      logic        fu_alu_done;
      logic [4:0]  rob_fu_alu;
      logic [31:0] data;
   } alu_data;

   typedef struct packed {
      logic [6:0]  p_mem;
      logic        fu_mem_done;
      logic [4:0]  rob_fu_mem;
      logic [31:0] data;
   } mem_data;

   typedef struct packed {
      logic [6:0]  p_b;
      logic        fu_b_done;
      logic        mispredict;
      logic [4:0]  mispredict_tag;
      logic        jalr_bne_signal;
      logic [31:0] pc;
      logic [31:0] data;
      logic [4:0]  rob_fu_b;
   } b_data;

   typedef struct packed {
      logic        valid;
      logic        prf_we;
      logic [6:0]  pd;
      logic [31:0] data;
      logic [4:0]  rob_tag;
      logic        mispredict;
      logic [4:0]  mispredict_tag;
      logic        jalr_bne;
      logic [31:0] pc;
      logic [1:0]  src;
   } cdb_data;

   // Entries are stored already in broadcast form; branch-only fields start at zero.
   function automatic cdb_data make_entry(input logic [6:0]  pd,
                                          input logic [4:0]  rob,
                                          input logic [31:0] data,
                                          input src_e        src);
      cdb_data e;
      e         = '0;
      e.valid   = 1'b1;
      e.prf_we  = (pd != 7'd0);
      e.pd      = pd;
      e.data    = data;
      e.rob_tag = rob;
      e.src     = src;
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// result_fifo: synchronous FIFO with flush and registered occupancy count.
// Rev 1.0
// ---------------------------------------------------------------------------
module result_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign dout    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
         if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wr_ptr_q] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/cdb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cdb_arbiter: buffers ALU/MEM/branch results and broadcasts one per cycle.
// Rev 1.0
// ---------------------------------------------------------------------------
module cdb_arbiter
   import types_pkg::*;
#(
   parameter int FIFO_DEPTH = CDB_FIFO_DEPTH
) (
   input  logic    clk,
   input  logic    rst_n,
   input  logic    flush,
   input  alu_data alu_in,
   input  mem_data mem_in,
   input  b_data   b_in,
   output logic    alu_ready,
   output logic    mem_ready,
   output logic    b_ready,
   output cdb_data cdb_out
);

   localparam int NSRC  = 3;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   cdb_data           entry [NSRC];
   cdb_data           head  [NSRC];
   logic [CNT_W-1:0]  cnt   [NSRC];
   logic [NSRC-1:0]   done, push, pop, full, empty, ready;

   src_e              rr_q, rr_d;
   cdb_data           cdb_q, cdb_d;
   src_e              grant_src;
   logic              grant_valid;

   assign done = {b_in.fu_b_done, mem_in.fu_mem_done, alu_in.fu_alu_done};

   always_comb begin
      entry[0] = make_entry(alu_in.p_alu, alu_in.rob_fu_alu, alu_in.data, SRC_ALU);
      entry[1] = make_entry(mem_in.p_mem, mem_in.rob_fu_mem, mem_in.data, SRC_MEM);
      entry[2] = make_entry(b_in.p_b, b_in.rob_fu_b, b_in.data, SRC_B);
      entry[2].mispredict     = b_in.mispredict;
      entry[2].mispredict_tag = b_in.mispredict_tag;
      entry[2].jalr_bne       = b_in.jalr_bne_signal;
      entry[2].pc             = b_in.pc;
   end

   for (genvar s = 0; s < NSRC; s++) begin : g_src
      assign ready[s] = (cnt[s] < CNT_W'(FIFO_DEPTH));
      assign push[s]  = done[s] & ready[s] & ~full[s] & ~flush;

      result_fifo #(
         .WIDTH ($bits(cdb_data)),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .flush (flush),
         .push  (push[s]),
         .pop   (pop[s]),
         .din   (entry[s]),
         .dout  (head[s]),
         .full  (full[s]),
         .empty (empty[s]),
         .count (cnt[s])
      );
   end

   assign alu_ready = ready[0];
   assign mem_ready = ready[1];
   assign b_ready   = ready[2];

   // Branch results preempt; ALU/MEM share the remaining slots round-robin.
   always_comb begin
      grant_valid = 1'b0;
      grant_src   = SRC_ALU;
      rr_d        = rr_q;
      pop         = '0;
      cdb_d       = '0;
      if (!empty[2]) begin
         grant_valid = 1'b1;
         grant_src   = SRC_B;
      end else if (!empty[0] && (empty[1] || rr_q == SRC_ALU)) begin
         grant_valid = 1'b1;
         grant_src   = SRC_ALU;
         rr_d        = SRC_MEM;
      end else if (!empty[1]) begin
         grant_valid = 1'b1;
         grant_src   = SRC_MEM;
         rr_d        = SRC_ALU;
      end
      if (flush) begin
         grant_valid = 1'b0;
         rr_d        = rr_q;
      end
      if (grant_valid) begin
         pop[grant_src] = 1'b1;
         cdb_d          = head[grant_src];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_q  <= SRC_ALU;
         cdb_q <= '0;
      end else begin
         rr_q  <= rr_d;
         cdb_q <= cdb_d;
      end
   end

   assign cdb_out = cdb_q;

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cdb_arbiter: directed scenarios with an in-order broadcast scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_cdb_arbiter;
   import types_pkg::*;

   logic    clk   = 1'b0;
   logic    rst_n = 1'b0;
   logic    flush = 1'b0;
   alu_data alu_in;
   mem_data mem_in;
   b_data   b_in;
   logic    alu_ready, mem_ready, b_ready;
   cdb_data cdb_out;

   int      checks = 0;
   int      passed = 0;
   cdb_data exp_q [$];
   cdb_data mon_e;
   logic    accepted;

   always #5 clk = ~clk;

   cdb_arbiter #(.FIFO_DEPTH(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .alu_in    (alu_in),
      .mem_in    (mem_in),
      .b_in      (b_in),
      .alu_ready (alu_ready),
      .mem_ready (mem_ready),
      .b_ready   (b_ready),
      .cdb_out   (cdb_out)
   );

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   function automatic cdb_data mk(input logic [1:0] src, input logic we, input logic [6:0] pd,
                                  input logic [4:0] rob, input logic [31:0] data,
                                  input logic misp, input logic [4:0] mtag,
                                  input logic jb, input logic [31:0] pc);
      cdb_data e;
      e.valid = 1'b1; e.prf_we = we; e.pd = pd; e.data = data; e.rob_tag = rob;
      e.mispredict = misp; e.mispredict_tag = mtag; e.jalr_bne = jb; e.pc = pc; e.src = src;
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      alu_in = '0;
      mem_in = '0;
      b_in   = '0;
   endtask

   task automatic alu(input logic [6:0] pd, input logic [4:0] rob, input logic [31:0] data);
      alu_in.p_alu = pd; alu_in.rob_fu_alu = rob; alu_in.data = data; alu_in.fu_alu_done = 1'b1;
   endtask

   task automatic mem(input logic [6:0] pd, input logic [4:0] rob, input logic [31:0] data);
      mem_in.p_mem = pd; mem_in.rob_fu_mem = rob; mem_in.data = data; mem_in.fu_mem_done = 1'b1;
   endtask

   task automatic br(input logic misp, input logic [4:0] mtag, input logic jb, input logic [31:0] pc,
                     input logic [6:0] pd, input logic [4:0] rob, input logic [31:0] data);
      b_in.mispredict = misp; b_in.mispredict_tag = mtag; b_in.jalr_bne_signal = jb;
      b_in.pc = pc; b_in.p_b = pd; b_in.rob_fu_b = rob; b_in.data = data; b_in.fu_b_done = 1'b1;
   endtask

   task automatic drain();
      repeat (8) step();
   endtask

   task automatic chk_ready(input string tag);
      chk({tag, "_alu_ready"}, alu_ready, 1'b1);
      chk({tag, "_mem_ready"}, mem_ready, 1'b1);
      chk({tag, "_b_ready"},   b_ready,   1'b1);
   endtask

   // Every valid broadcast must match the next expected result, in order.
   always @(negedge clk) begin
      if (cdb_out.valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_broadcast", cdb_out, '0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("cdb_broadcast", cdb_out, mon_e);
         end
      end
   end

   initial begin
      idle();
      rst_n = 1'b0;
      repeat (3) step();
      rst_n = 1'b1;
      chk("reset_cdb_out", cdb_out, '0);
      chk_ready("reset");

      // Single ALU result.
      exp_q.push_back(mk(2'd0, 1'b1, 7'd10, 5'd3, 32'h55, 1'b0, 5'd0, 1'b0, 32'h0));
      alu(7'd10, 5'd3, 32'h55);
      step(); idle(); drain();

      // Reset while results are buffered: nothing may be broadcast.
      alu(7'd1, 5'd1, 32'h1); mem(7'd2, 5'd2, 32'h2); br(1'b1, 5'd3, 1'b1, 32'h3, 7'd3, 5'd3, 32'h3);
      step(); idle();
      rst_n = 1'b0;
      step(); step();
      rst_n = 1'b1;
      chk("midreset_cdb_out", cdb_out, '0);
      chk_ready("midreset");
      drain();

      // ALU and MEM together after reset: ALU first.
      exp_q.push_back(mk(2'd0, 1'b1, 7'd5, 5'd4, 32'hA5, 1'b0, 5'd0, 1'b0, 32'h0));
      exp_q.push_back(mk(2'd1, 1'b1, 7'd6, 5'd5, 32'hB6, 1'b0, 5'd0, 1'b0, 32'h0));
      alu(7'd5, 5'd4, 32'hA5); mem(7'd6, 5'd5, 32'hB6);
      step(); idle(); drain();

      // Mispredicting branch and ALU together: branch first.
      exp_q.push_back(mk(2'd2, 1'b1, 7'd20, 5'd7, 32'hC0, 1'b1, 5'd7, 1'b0, 32'h100));
      exp_q.push_back(mk(2'd0, 1'b1, 7'd21, 5'd8, 32'hC1, 1'b0, 5'd0, 1'b0, 32'h0));
      br(1'b1, 5'd7, 1'b0, 32'h100, 7'd20, 5'd7, 32'hC0); alu(7'd21, 5'd8, 32'hC1);
      step(); idle(); drain();

      // Branch stream hogs the CDB while three ALU results arrive.
      for (int i = 0; i < 4; i++)
         exp_q.push_back(mk(2'd2, 1'b1, 7'(30 + i), 5'(10 + i), 32'hB0 + i, 1'b0, 5'd0, 1'(i), 32'h200 + i));
      exp_q.push_back(mk(2'd0, 1'b1, 7'd40, 5'd20, 32'hA1, 1'b0, 5'd0, 1'b0, 32'h0));
      exp_q.push_back(mk(2'd0, 1'b1, 7'd41, 5'd21, 32'hA2, 1'b0, 5'd0, 1'b0, 32'h0));
      exp_q.push_back(mk(2'd0, 1'b1, 7'd42, 5'd22, 32'hA3, 1'b0, 5'd0, 1'b0, 32'h0));
      br(1'b0, 5'd0, 1'b0, 32'h200, 7'd30, 5'd10, 32'hB0); alu(7'd40, 5'd20, 32'hA1);
      step();
      br(1'b0, 5'd0, 1'b1, 32'h201, 7'd31, 5'd11, 32'hB1); alu(7'd41, 5'd21, 32'hA2);
      step();
      chk("hog_alu_ready_full1", alu_ready, 1'b0);
      br(1'b0, 5'd0, 1'b0, 32'h202, 7'd32, 5'd12, 32'hB2); alu(7'd42, 5'd22, 32'hA3);
      step();
      chk("hog_alu_ready_full2", alu_ready, 1'b0);
      br(1'b0, 5'd0, 1'b1, 32'h203, 7'd33, 5'd13, 32'hB3);
      step();
      b_in = '0;
      accepted = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (alu_ready) begin
            accepted = 1'b1;
            step();
            break;
         end
         step();
      end
      chk("hog_third_alu_accepted", accepted, 1'b1);
      idle(); drain();

      // Flush with 2 ALU + 1 MEM buffered; only the already-granted branch appears.
      exp_q.push_back(mk(2'd2, 1'b1, 7'd50, 5'd1, 32'hD0, 1'b0, 5'd0, 1'b0, 32'h300));
      br(1'b0, 5'd0, 1'b0, 32'h300, 7'd50, 5'd1, 32'hD0); alu(7'd51, 5'd2, 32'hD1); mem(7'd52, 5'd3, 32'hD2);
      step();
      idle();
      br(1'b0, 5'd0, 1'b0, 32'h301, 7'd53, 5'd4, 32'hD3); alu(7'd54, 5'd5, 32'hD4);
      step();
      idle();
      flush = 1'b1;
      mem(7'd55, 5'd6, 32'hD5);
      step();
      flush = 1'b0;
      idle();
      chk_ready("flush");
      drain();

      // Pointer survived the flush favouring MEM.
      exp_q.push_back(mk(2'd1, 1'b1, 7'd61, 5'd11, 32'hE1, 1'b0, 5'd0, 1'b0, 32'h0));
      exp_q.push_back(mk(2'd0, 1'b1, 7'd60, 5'd10, 32'hE0, 1'b0, 5'd0, 1'b0, 32'h0));
      alu(7'd60, 5'd10, 32'hE0); mem(7'd61, 5'd11, 32'hE1);
      step(); idle(); drain();

      // Destination register 0: broadcast without PRF write.
      exp_q.push_back(mk(2'd0, 1'b0, 7'd0, 5'd9, 32'h77, 1'b0, 5'd0, 1'b0, 32'h0));
      alu(7'd0, 5'd9, 32'h77);
      step(); idle(); drain();

      chk("all_expected_broadcast", exp_q.size(), 0);
      chk_ready("final");
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, meaning result entries buffered per functional-unit source.
REQ-002 SHALL have port clk, input, 1, the single clock.
REQ-003 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port flush, input, 1, which discards all buffered results.
REQ-005 SHALL have port alu_in, input, alu_data, the ALU result (p_alu, fu_alu_done, rob_fu_alu, data).
REQ-006 SHALL have port mem_in, input, mem_data, the memory result (p_mem, fu_mem_done, rob_fu_mem, data).
REQ-007 SHALL have port b_in, input, b_data, the branch result (p_b, fu_b_done, mispredict, mispredict_tag, jalr_bne_signal, pc, data, rob_fu_b).
REQ-008 SHALL have ports alu_ready, mem_ready and b_ready, each output, 1, high when that source's FIFO can accept a result.
REQ-009 SHALL have port cdb_out, output, cdb_data, the registered broadcast to ROB, PRF and RS.

Function
REQ-010 SHALL accept a result from a source in a cycle only when that source's done bit and its ready output are both 1 and flush is 0.
REQ-011 SHALL drive each ready output as (registered FIFO count < FIFO_DEPTH); a full FIFO SHALL NOT accept a result, even in a cycle in which it pops.
REQ-012 SHALL, each cycle, grant at most one FIFO head: a non-empty branch FIFO wins; otherwise ALU and MEM alternate round-robin.
REQ-013 SHALL update the round-robin pointer only when ALU or MEM is granted; the pointer then favours the other source.
REQ-014 SHALL pop the granted head and register it onto cdb_out, so a result accepted in cycle N is broadcast no earlier than cycle N+1.
REQ-015 SHALL drive cdb_out.valid for exactly one cycle per granted result, and drive it to 0 in any cycle without a grant.
REQ-016 SHALL set cdb_out.prf_we = valid and (pd != 0).
REQ-017 SHALL pass mispredict, mispredict_tag, jalr_bne and pc from branch results, and force them to 0 for ALU and MEM results.
REQ-018 SHALL encode cdb_out.src as 0=ALU, 1=MEM, 2=B.
REQ-019 SHALL preserve FIFO order within each source.
REQ-020 SHALL let a FIFO push and pop in the same cycle when it is not full, leaving its count unchanged.
REQ-021 SHALL, on flush, empty all FIFOs, drop all same-cycle inputs, and drive cdb_out.valid=0 in the next cycle.
REQ-022 SHALL, on flush, leave the round-robin pointer unchanged.
REQ-023 SHALL wrap FIFO pointers modulo FIFO_DEPTH.

Reset
REQ-024 SHALL, when rst_n=0 at a clk edge, clear all FIFO counts and pointers, set cdb_out to all zeros, and set the round-robin pointer to ALU.
REQ-025 SHALL drive every ready output to 1 in the first cycle after reset deasserts.
REQ-026 SHALL let reset mid-operation discard all in-flight results with no broadcast.

Structure
REQ-027 SHALL define the cdb_data typedef in types_pkg with fields valid, prf_we, pd[6:0], data[31:0], rob_tag[4:0], mispredict, mispredict_tag[4:0], jalr_bne, pc[31:0], src[1:0].
REQ-028 SHALL define the constant CDB_FIFO_DEPTH=2 in types_pkg.
REQ-029 SHALL instantiate one sub-module, result_fifo, three times: a parameterised synchronous FIFO with push, pop, full, empty, count and flush ports.

Verification
REQ-030 SHALL include scenario: ALU done, pd=10, rob=3, data=0x55 in cycle 1 -> cycle 2 cdb valid, pd=10, rob_tag=3, data=0x55, prf_we=1, src=0.
REQ-031 SHALL include scenario: ALU (pd=5) and MEM (pd=6) done together in cycle 1 after reset -> ALU broadcast cycle 2, MEM broadcast cycle 3.
REQ-032 SHALL include scenario: branch mispredict (tag=7, pc=0x100) plus ALU done in the same cycle -> branch first with mispredict=1 and mispredict_tag=7, then ALU.
REQ-033 SHALL include scenario: three ALU results on consecutive cycles while a branch stream hogs the CDB -> alu_ready=0 after two are buffered; third accepted once ready returns; order preserved.
REQ-034 SHALL include scenario: flush asserted while 2 ALU and 1 MEM results are buffered -> no broadcasts follow and all ready outputs return to 1.
REQ-035 SHALL include scenario: ALU result with pd=0 -> valid=1 and prf_we=0.
